led_group_ctrl: RTL and testbench

Control front-end for the switch-to-LED group datapath. Takes the four raw push-buttons, synchronises and debounces each one, and turns every debounced press into a toggle of a persistent per-group blanking mask. That mask drives the datapath's group-off inputs, so a group stays dark after the button is released. Sits between the board button pins and `switch_led_groups`; the switch and LED paths are untouched.

---
 rtl/led_ctrl_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 79 +++++++
 rtl/led_group_ctrl.sv | 94 +++++++++
 tb/tb_led_group_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// ============================================================================
// Module      : led_ctrl_pkg
// Description : Shared constants, types and helpers for the LED group
//               control front-end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_ctrl_pkg;

  localparam int NUM_GROUPS = 4;
  localparam int GROUP_W    = 4;

  // 10 ms of stable level at 100 MHz; half a second per group when scanning
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_SCAN_CYCLES     = 50_000_000;

  typedef logic [NUM_GROUPS-1:0] group_mask_t;

  // One-hot blanking pattern selecting a single group
  function automatic group_mask_t group_onehot(input logic [1:0] idx);
    group_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : 2-FF synchroniser plus counting debouncer for one button.
//               Emits the accepted level and a one-cycle pulse on each
//               accepted rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;
  logic             stable_dly_q;
  logic             rise_q;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state and registered rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      rise_q       <= stable_q & ~stable_dly_q;
    end
  end

  assign level = stable_q;
  assign rise  = rise_q;

endmodule

`default_nettype wire

// File: rtl/led_group_ctrl.sv
// ============================================================================
// Module      : led_group_ctrl
// Description : Debounces four push-buttons and toggles a persistent
//               per-group blanking mask on every accepted press.
//               Optional build macro LED_GROUP_SCAN_EN adds a scan_mode input
//               that rotates a single blanked group automatically.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_group_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SCAN_CYCLES     = DEFAULT_SCAN_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_GROUPS-1:0] btn_raw,
`ifdef LED_GROUP_SCAN_EN
  input  logic                  scan_mode,
`endif
  output logic [NUM_GROUPS-1:0] press_evt,
  output group_mask_t           group_off
);

  // Reject configurations the counters and the 16-LED datapath cannot support
  if (DEBOUNCE_CYCLES < 2 || SCAN_CYCLES < 2 || NUM_GROUPS * GROUP_W != 16) begin : g_param_check
    $error("led_group_ctrl: unsupported parameter set");
  end

  group_mask_t w_rise;
  group_mask_t w_level_unused;  // accepted levels, not needed by the mask logic
  group_mask_t mask_q;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk   (clk),
      .rst   (rst),
      .din   (btn_raw[g]),
      .level (w_level_unused[g]),
      .rise  (w_rise[g])
    );
  end

  assign press_evt = w_rise;

  // Each accepted press flips its group's blanking bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_q ^ w_rise;
    end
  end

`ifdef LED_GROUP_SCAN_EN
  localparam int                SCAN_W    = $clog2(SCAN_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic              scan_act_q;
  logic [SCAN_W-1:0] scan_cnt_q;
  logic [1:0]        scan_ptr_q;

  // Dwell counter and group pointer; parked at zero whenever scanning is off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_act_q <= 1'b0;
      scan_cnt_q <= '0;
      scan_ptr_q <= 2'd0;
    end else begin
      scan_act_q <= scan_mode;
      if (!scan_mode || !scan_act_q) begin
        scan_cnt_q <= '0;
        scan_ptr_q <= 2'd0;
      end else if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q <= '0;
        scan_ptr_q <= scan_ptr_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
      end
    end
  end

  assign group_off = scan_act_q ? group_onehot(scan_ptr_q) : mask_q;
`else
  assign group_off = mask_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_group_ctrl.sv
// ============================================================================
// Module      : tb_led_group_ctrl
// Description : Self-checking bench for led_group_ctrl with a scoreboard of
//               predicted press events and a reference debounce model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_group_ctrl;
  import led_ctrl_pkg::*;

  localparam int D = 4;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       scan_mode;
  logic [3:0] press_evt;
  logic [3:0] group_off;

  always #5 clk = ~clk;

  led_group_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .SCAN_CYCLES     (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
`ifdef LED_GROUP_SCAN_EN
    .scan_mode (scan_mode),
`endif
    .press_evt (press_evt),
    .group_off (group_off)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] evt;
    logic [3:0] mask_after;
  } exp_t;

  exp_t sb[$];

  // Reference model: raw history, accepted levels, run lengths, mask
  logic [3:0] h1, h2, stab, mmask;
  int         run [4];
  int         total = 0;
  int         bad   = 0;
  bit         in_scan = 1'b0;

  task automatic model_reset();
    h1 = '0; h2 = '0; stab = '0; mmask = '0;
    for (int g = 0; g < 4; g++) run[g] = 0;
    sb.delete();
  endtask

  // Drive the inputs for the coming edge and predict its effect. A level is
  // accepted after D consecutive synchronised samples that disagree with it.
  task automatic apply(input logic [3:0] b);
    logic [3:0] ev;
    btn_raw = b;
    ev = '0;
    for (int g = 0; g < 4; g++) begin
      if (h2[g] != stab[g]) begin
        run[g]++;
        if (run[g] == D) begin
          stab[g] = ~stab[g];
          run[g]  = 0;
          if (stab[g]) ev[g] = 1'b1;
        end
      end else begin
        run[g] = 0;
      end
    end
    h2 = h1;
    h1 = b;
    if (ev != '0) begin
      mmask = mmask ^ ev;
      sb.push_back('{cyc + 2, ev, mmask});
    end
  endtask

  task automatic step(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      apply(b);
    end
  endtask

  task automatic do_reset(input int len);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    repeat (len) @(negedge clk);
    #2 rst = 1'b0;
    apply(btn_raw);
  endtask

  // Monitor: pops predicted events whenever the DUT pulses press_evt
  logic [3:0] cur_off = '0;
  logic [3:0] pend_val = '0;
  bit         pend = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        total++;
        if (press_evt !== 4'b0 || group_off !== 4'b0) begin
          bad++;
          $display("FAIL reset_state t=%0d press_evt=%b group_off=%b required 0000/0000", cyc, press_evt, group_off);
        end
        cur_off = '0;
        pend    = 1'b0;
      end else begin
        if (pend) begin
          cur_off = pend_val;
          pend    = 1'b0;
        end
        if (!in_scan) begin
          total++;
          if (group_off !== cur_off) begin
            bad++;
            $display("FAIL group_off t=%0d got=%b required=%b", cyc, group_off, cur_off);
          end
        end
        if (press_evt !== 4'b0) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event t=%0d got=%b required=0000", cyc, press_evt);
          end else begin
            e = sb.pop_front();
            if (press_evt !== e.evt || cyc != e.at) begin
              bad++;
              $display("FAIL press_evt t=%0d got=%b required=%b at t=%0d", cyc, press_evt, e.evt, e.at);
            end
            pend     = 1'b1;
            pend_val = e.mask_after;
          end
        end else if (sb.size() > 0 && sb[0].at <= cyc) begin
          total++;
          bad++;
          e = sb.pop_front();
          $display("FAIL missed_event t=%0d got=0000 required=%b at t=%0d", cyc, e.evt, e.at);
          pend     = 1'b1;
          pend_val = e.mask_after;
        end
      end
    end
  end

  initial begin
    logic [3:0] cur;
    rst       = 1'b1;
    btn_raw   = '0;
    scan_mode = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    apply(4'b0000);

    // Clean press, release, second press
    step(4'b0001, 20);
    step(4'b0000, 10);
    step(4'b0001, 20);
    step(4'b0000, 10);

    // Bouncing button, then a firm hold
    step(4'b0010, 1);
    step(4'b0000, 1);
    step(4'b0010, 1);
    step(4'b0000, 1);
    step(4'b0010, 15);
    step(4'b0000, 10);

    // Simultaneous presses, then a single one
    step(4'b0101, 15);
    step(4'b0000, 10);
    step(4'b0001, 15);
    step(4'b0000, 10);

    // Reset in the middle of a debounce with the button still held
    step(4'b0100, 3);
    do_reset(1);
    step(4'b0100, 15);
    step(4'b0000, 10);

`ifdef LED_GROUP_SCAN_EN
    // Scan rotation with mask 1000, then return to the mask
    do_reset(2);
    step(4'b1000, 12);
    step(4'b0000, 10);
    @(negedge clk);
    scan_mode = 1'b1;
    in_scan   = 1'b1;
    apply(4'b0000);
    for (int i = 0; i < 15; i++) begin
      logic [3:0] exp_oh;
      @(negedge clk);
      exp_oh = 4'b0001 << ((i / S) % 4);
      total++;
      if (group_off !== exp_oh) begin
        bad++;
        $display("FAIL scan_step i=%0d got=%b required=%b", i, group_off, exp_oh);
      end
      apply(4'b0000);
    end
    scan_mode = 1'b0;
    @(negedge clk);
    total++;
    if (group_off !== 4'b1000) begin
      bad++;
      $display("FAIL scan_exit got=%b required=1000", group_off);
    end
    in_scan = 1'b0;
    apply(4'b0000);
`endif

    // Randomised bouncing on all buttons with occasional resets
    cur = '0;
    for (int k = 0; k < 400; k++) begin
      for (int g = 0; g < 4; g++)
        if ($urandom_range(0, 4) == 0) cur[g] = ~cur[g];
      if ($urandom_range(0, 99) == 0) do_reset(int'($urandom_range(1, 3)));
      step(cur, 1);
    end
    step(cur, 15);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
